// File: rtl/pipe_sched_ctl.sv
// pipe_sched_ctl: mips789 pipeline sequencing controller (post-reset PC forcing, load-use
// interlock, HI/LO wait, interrupt entry). Optional stall counter: PIPE_SCHED_STALL_CNT_EN.
module pipe_sched_ctl #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_hilo,
    input  logic             id_in_dslot,
    input  logic             ex_load,
    input  logic [4:0]       ex_rd,
    input  logic             md_busy,
    input  logic             irq_req,
    input  logic             irq_en,
    input  logic             isr_ret,
    output logic             pause,
    output logic             rd_clk_cls,
    output logic [3:0]       pc_prectl,
    output logic             id_flush,
    output logic             epc_we,
    output logic             irq_ack,
    output logic [CNT_W-1:0] stall_cnt
);
    // PC override codes shared with the next-PC generator
    localparam logic [3:0] PC_IGN = 4'd0;
    localparam logic [3:0] PC_KEP = 4'd1;
    localparam logic [3:0] PC_IRQ = 4'd2;
    localparam logic [3:0] PC_RST = 4'd3;

    typedef enum logic [1:0] {
        S_RESET     = 2'd0,
        S_RUN       = 2'd1,
        S_MD_WAIT   = 2'd2,
        S_IRQ_ENTER = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] rcnt_q, rcnt_d;
    logic       in_isr_q, in_isr_d;

    logic md_wait_cond;
    logic lu_cond;
    logic irq_take;

    assign md_wait_cond = id_use_hilo & md_busy;
    assign lu_cond      = ex_load & (ex_rd != 5'd0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
    // A coincident isr_ret blocks the take so the return completes first.
    assign irq_take     = irq_req & irq_en & ~in_isr_q & ~id_in_dslot
                          & ~md_wait_cond & ~lu_cond & ~isr_ret;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q  <= S_RESET;
            rcnt_q   <= 4'd0;
            in_isr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            in_isr_q <= in_isr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        in_isr_d   = in_isr_q;
        pause      = 1'b0;
        rd_clk_cls = 1'b0;
        pc_prectl  = PC_IGN;
        id_flush   = 1'b0;
        epc_we     = 1'b0;
        irq_ack    = 1'b0;

        case (state_q)
            S_RESET: begin
                pc_prectl = PC_RST;
                id_flush  = 1'b1;
                rcnt_d    = rcnt_q + 4'd1;
                if (rcnt_q == 4'(RST_CYCLES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (irq_take) begin
                    state_d = S_IRQ_ENTER;
                end else if (md_wait_cond) begin
                    pause      = 1'b1;
                    rd_clk_cls = 1'b1;
                    state_d    = S_MD_WAIT;
                end else if (lu_cond) begin
                    pc_prectl  = PC_KEP;
                    rd_clk_cls = 1'b1;
                    id_flush   = 1'b1;
                end
            end
            S_MD_WAIT: begin
                if (md_busy) begin
                    pause      = 1'b1;
                    rd_clk_cls = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_IRQ_ENTER: begin
                pc_prectl = PC_IRQ;
                epc_we    = 1'b1;
                irq_ack   = 1'b1;
                id_flush  = 1'b1;
                in_isr_d  = 1'b1;
                state_d   = S_RUN;
            end
            default: state_d = S_RESET;
        endcase

        if (isr_ret) begin
            in_isr_d = 1'b0;
        end
    end

`ifdef PIPE_SCHED_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             stall_now;

    // Counts freeze cycles plus the single-cycle load-use bubble.
    assign stall_now = pause | ((state_q == S_RUN) & ~irq_take & ~md_wait_cond & lu_cond);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall_now && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_sched_ctl.sv
// Directed bench for pipe_sched_ctl: reset sequencing, load-use, mul/div wait, IRQ entry/blocking, async reset.
module tb_pipe_sched_ctl;
    localparam int CNT_W = 32;
    localparam logic [3:0] PC_IGN = 4'd0;
    localparam logic [3:0] PC_KEP = 4'd1;
    localparam logic [3:0] PC_IRQ = 4'd2;
    localparam logic [3:0] PC_RST = 4'd3;

    logic             clock = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_rs = '0, id_rt = '0, ex_rd = '0;
    logic             id_use_hilo = 0, id_in_dslot = 0, ex_load = 0, md_busy = 0;
    logic             irq_req = 0, irq_en = 0, isr_ret = 0;
    logic             pause, rd_clk_cls, id_flush, epc_we, irq_ack;
    logic [3:0]       pc_prectl;
    logic [CNT_W-1:0] stall_cnt;

    int n_pass = 0;
    int n_tot = 0;
    logic [CNT_W-1:0] exp_stalls = '0;

    pipe_sched_ctl #(.RST_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clock(clock), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_hilo(id_use_hilo), .id_in_dslot(id_in_dslot), .ex_load(ex_load),
        .ex_rd(ex_rd), .md_busy(md_busy), .irq_req(irq_req), .irq_en(irq_en),
        .isr_ret(isr_ret), .pause(pause), .rd_clk_cls(rd_clk_cls), .pc_prectl(pc_prectl),
        .id_flush(id_flush), .epc_we(epc_we), .irq_ack(irq_ack), .stall_cnt(stall_cnt)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_use_hilo = 0; id_in_dslot = 0; ex_load = 0; md_busy = 0;
        irq_req = 0; isr_ret = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        irq_en = 1;
        rst = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_tot++;
            if (pc_prectl !== PC_RST || id_flush !== 1'b1 || pause !== 1'b0 || irq_ack !== 1'b0)
                $display("FAIL reset_hold: got pc=%0d flush=%0b pause=%0b ack=%0b want pc=3 flush=1 pause=0 ack=0",
                         pc_prectl, id_flush, pause, irq_ack);
            else n_pass++;
            tick();
        end
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_tot++;
            if (c < 4) begin
                if (pc_prectl !== PC_RST || id_flush !== 1'b1 || pause !== 1'b0)
                    $display("FAIL reset_release_%0d: got pc=%0d flush=%0b pause=%0b want pc=3 flush=1 pause=0",
                             c, pc_prectl, id_flush, pause);
                else n_pass++;
            end else begin
                if (pc_prectl !== PC_IGN || id_flush !== 1'b0 || pause !== 1'b0)
                    $display("FAIL reset_run: got pc=%0d flush=%0b pause=%0b want pc=0 flush=0 pause=0",
                             pc_prectl, id_flush, pause);
                else n_pass++;
            end
            tick();
        end
        exp_stalls = '0;
        n_tot++;
        if (stall_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_load_use();
        ex_load = 1; ex_rd = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
        @(negedge clock);
        n_tot++;
        if (pc_prectl !== PC_KEP || rd_clk_cls !== 1'b1 || id_flush !== 1'b1 || pause !== 1'b0)
            $display("FAIL lu_rs: got pc=%0d rcc=%0b flush=%0b pause=%0b want pc=1 rcc=1 flush=1 pause=0",
                     pc_prectl, rd_clk_cls, id_flush, pause);
        else n_pass++;
        exp_stalls++;
        tick();
        ex_load = 0;
        @(negedge clock);
        n_tot++;
        if (pc_prectl !== PC_IGN || rd_clk_cls !== 1'b0 || id_flush !== 1'b0)
            $display("FAIL lu_release: got pc=%0d rcc=%0b flush=%0b want pc=0 rcc=0 flush=0",
                     pc_prectl, rd_clk_cls, id_flush);
        else n_pass++;
        tick();
        ex_load = 1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        @(negedge clock);
        n_tot++;
        if (pc_prectl !== PC_IGN || rd_clk_cls !== 1'b0 || id_flush !== 1'b0)
            $display("FAIL lu_r0: got pc=%0d rcc=%0b flush=%0b want pc=0 rcc=0 flush=0",
                     pc_prectl, rd_clk_cls, id_flush);
        else n_pass++;
        tick();
        ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
        @(negedge clock);
        n_tot++;
        if (pc_prectl !== PC_KEP || rd_clk_cls !== 1'b1 || id_flush !== 1'b1)
            $display("FAIL lu_rt: got pc=%0d rcc=%0b flush=%0b want pc=1 rcc=1 flush=1",
                     pc_prectl, rd_clk_cls, id_flush);
        else n_pass++;
        exp_stalls++;
        tick();
        ex_rd = 5'd8;
        @(negedge clock);
        n_tot++;
        if (pc_prectl !== PC_IGN)
            $display("FAIL lu_nomatch: got pc=%0d want pc=0", pc_prectl);
        else n_pass++;
        tick();
        idle_inputs();
    endtask

    task automatic test_md_wait();
        id_use_hilo = 1; md_busy = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            n_tot++;
            if (pause !== 1'b1 || rd_clk_cls !== 1'b1 || pc_prectl !== PC_IGN || epc_we !== 1'b0)
                $display("FAIL md_busy_%0d: got pause=%0b rcc=%0b pc=%0d epc=%0b want pause=1 rcc=1 pc=0 epc=0",
                         c, pause, rd_clk_cls, pc_prectl, epc_we);
            else n_pass++;
            exp_stalls++;
            tick();
        end
        md_busy = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            n_tot++;
            if (pause !== 1'b0 || rd_clk_cls !== 1'b0)
                $display("FAIL md_release_%0d: got pause=%0b rcc=%0b want pause=0 rcc=0", c, pause, rd_clk_cls);
            else n_pass++;
            tick();
        end
        idle_inputs();
`ifdef PIPE_SCHED_STALL_CNT_EN
        n_tot++;
        if (stall_cnt !== exp_stalls) $display("FAIL md_cnt: got %0d want %0d", stall_cnt, exp_stalls);
        else n_pass++;
`else
        n_tot++;
        if (stall_cnt !== '0) $display("FAIL md_cnt_off: got %0d want 0", stall_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_irq();
        irq_req = 1;
        @(negedge clock);
        n_tot++;
        if (irq_ack !== 1'b0 || pc_prectl !== PC_IGN)
            $display("FAIL irq_take_cycle: got ack=%0b pc=%0d want ack=0 pc=0", irq_ack, pc_prectl);
        else n_pass++;
        tick();
        @(negedge clock);
        n_tot++;
        if (pc_prectl !== PC_IRQ || epc_we !== 1'b1 || irq_ack !== 1'b1 || id_flush !== 1'b1 || pause !== 1'b0)
            $display("FAIL irq_enter: got pc=%0d epc=%0b ack=%0b flush=%0b pause=%0b want pc=2 epc=1 ack=1 flush=1 pause=0",
                     pc_prectl, epc_we, irq_ack, id_flush, pause);
        else n_pass++;
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_tot++;
            if (irq_ack !== 1'b0 || pc_prectl !== PC_IGN)
                $display("FAIL irq_in_isr_%0d: got ack=%0b pc=%0d want ack=0 pc=0", c, irq_ack, pc_prectl);
            else n_pass++;
            tick();
        end
        isr_ret = 1;
        tick();
        isr_ret = 0;
        tick();
        @(negedge clock);
        n_tot++;
        if (irq_ack !== 1'b1 || pc_prectl !== PC_IRQ)
            $display("FAIL irq_retake: got ack=%0b pc=%0d want ack=1 pc=2", irq_ack, pc_prectl);
        else n_pass++;
        tick();
        irq_req = 0;
        isr_ret = 1;
        tick();
        // isr_ret coincident with a fresh request: the return wins this cycle
        irq_req = 1;
        isr_ret = 1;
        tick();
        isr_ret = 0;
        @(negedge clock);
        n_tot++;
        if (irq_ack !== 1'b0)
            $display("FAIL irq_ret_coincide: got ack=%0b want ack=0", irq_ack);
        else n_pass++;
        tick();
        @(negedge clock);
        n_tot++;
        if (irq_ack !== 1'b1)
            $display("FAIL irq_after_ret: got ack=%0b want ack=1", irq_ack);
        else n_pass++;
        tick();
        irq_req = 0;
        isr_ret = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_irq_block();
        irq_req = 1; id_in_dslot = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_tot++;
            if (irq_ack !== 1'b0 || pc_prectl !== PC_IGN)
                $display("FAIL irq_dslot_%0d: got ack=%0b pc=%0d want ack=0 pc=0", c, irq_ack, pc_prectl);
            else n_pass++;
            tick();
        end
        id_in_dslot = 0;
        tick();
        @(negedge clock);
        n_tot++;
        if (irq_ack !== 1'b1)
            $display("FAIL irq_dslot_release: got ack=%0b want ack=1", irq_ack);
        else n_pass++;
        tick();
        irq_req = 0;
        isr_ret = 1;
        tick();
        isr_ret = 0;
        irq_req = 1; id_use_hilo = 1; md_busy = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            n_tot++;
            if (irq_ack !== 1'b0 || pause !== 1'b1)
                $display("FAIL irq_md_%0d: got ack=%0b pause=%0b want ack=0 pause=1", c, irq_ack, pause);
            else n_pass++;
            exp_stalls++;
            tick();
        end
        md_busy = 0; id_use_hilo = 0;
        @(negedge clock);
        n_tot++;
        if (irq_ack !== 1'b0 || pause !== 1'b0)
            $display("FAIL irq_md_release: got ack=%0b pause=%0b want ack=0 pause=0", irq_ack, pause);
        else n_pass++;
        tick();
        tick();
        @(negedge clock);
        n_tot++;
        if (irq_ack !== 1'b1 || epc_we !== 1'b1 || pause !== 1'b0)
            $display("FAIL irq_md_take: got ack=%0b epc=%0b pause=%0b want ack=1 epc=1 pause=0",
                     irq_ack, epc_we, pause);
        else n_pass++;
        tick();
        irq_req = 0;
        isr_ret = 1;
        tick();
        idle_inputs();
`ifdef PIPE_SCHED_STALL_CNT_EN
        n_tot++;
        if (stall_cnt !== exp_stalls) $display("FAIL block_cnt: got %0d want %0d", stall_cnt, exp_stalls);
        else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        irq_req = 1;
        tick();
        #1;
        n_tot++;
        if (irq_ack !== 1'b1)
            $display("FAIL async_pre: got ack=%0b want ack=1", irq_ack);
        else n_pass++;
        rst = 1;
        #1;
        n_tot++;
        if (pc_prectl !== PC_RST || irq_ack !== 1'b0 || epc_we !== 1'b0 || id_flush !== 1'b1)
            $display("FAIL async_rst: got pc=%0d ack=%0b epc=%0b flush=%0b want pc=3 ack=0 epc=0 flush=1",
                     pc_prectl, irq_ack, epc_we, id_flush);
        else n_pass++;
        irq_req = 0;
        tick();
        tick();
        rst = 0;
        exp_stalls = '0;
        for (int c = 0; c < 4; c++) tick();
        irq_req = 1;
        @(negedge clock);
        n_tot++;
        if (stall_cnt !== exp_stalls || pc_prectl !== PC_IGN)
            $display("FAIL async_run: got cnt=%0d pc=%0d want cnt=0 pc=0", stall_cnt, pc_prectl);
        else n_pass++;
        tick();
        @(negedge clock);
        n_tot++;
        if (irq_ack !== 1'b1)
            $display("FAIL async_isr_cleared: got ack=%0b want ack=1", irq_ack);
        else n_pass++;
        tick();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_md_wait();
        test_irq();
        test_irq_block();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
